// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage: memory op codes, FSM states
// and op classification.
package mem_stage_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    LW   = 3'd1,
    LBU  = 3'd2,
    SW   = 3'd3,
    SB   = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } mem_state_e;

  function automatic logic is_mem_op(mem_op_e op);
    return op inside {LW, LBU, SW, SB};
  endfunction

  function automatic logic is_store_op(mem_op_e op);
    return op inside {SW, SB};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
// Request: a transfer happens on a cycle with dmem_req_valid_o & dmem_req_ready_i;
// the master holds valid and all request fields stable until that cycle, and
// ready may depend on valid. Response: dmem_resp_valid_i is a one-cycle pulse
// with no back-pressure.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req_valid_o;
  logic              dmem_req_ready_i;
  logic [WORD_W-1:0] dmem_addr_o;
  logic              dmem_we_o;
  logic [3:0]        dmem_mask_o;
  logic [WORD_W-1:0] dmem_wdata_o;
  logic              dmem_resp_valid_i;
  logic [WORD_W-1:0] dmem_resp_data_i;

  modport master (
    output dmem_req_valid_o, dmem_addr_o, dmem_we_o, dmem_mask_o, dmem_wdata_o,
    input  dmem_req_ready_i, dmem_resp_valid_i, dmem_resp_data_i
  );

  modport slave (
    input  dmem_req_valid_o, dmem_addr_o, dmem_we_o, dmem_mask_o, dmem_wdata_o,
    output dmem_req_ready_i, dmem_resp_valid_i, dmem_resp_data_i
  );

endinterface

// File: rtl/mem_stage_byte_lane.sv
// Byte-lane steering: store byte-enables and data replication, and load
// byte extraction (little-endian, lane 0 = bits 7:0).
module mem_byte_lane
  import mem_stage_pkg::*;
(
  input  mem_op_e           op,
  input  logic [1:0]        addr,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] resp_data,
  output logic [3:0]        mask,
  output logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data
);

  always_comb begin
    mask      = 4'h0;
    wdata     = store_data;
    load_data = resp_data;
    case (op)
      LW, SW: mask = 4'hF;
      LBU: begin
        mask      = 4'b0001 << addr;
        load_data = {24'h0, resp_data[{addr, 3'b000} +: 8]};
      end
      SB: begin
        mask  = 4'b0001 << addr;
        wdata = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through, or issues one data-memory request
// per load/store and stalls upstream until it completes.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_WIDTH-1:0]     result_i,
  input  logic [DATA_WIDTH-1:0]     store_data_i,
  input  logic [2:0]                mem_op_i,
  input  logic                      wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
  mem_stage_if.master               dmem,
  output logic                      wb_valid_o,
  output logic                      wb_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output mem_state_e                dbg_state
);

  mem_state_e                state_q, state_d;
  mem_op_e                   op_in, op_q;
  logic [DATA_WIDTH-1:0]     addr_q, sdata_q;
  logic                      wb_en_q;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q;
  logic                      accept, req_fire, store_done, load_done;
  logic [3:0]                lane_mask;
  logic [DATA_WIDTH-1:0]     lane_wdata, lane_load;

  assign op_in      = mem_op_e'(mem_op_i);
  assign dbg_state  = state_q;
  assign accept     = valid_i & ready_o;
  assign req_fire   = dmem.dmem_req_valid_o & dmem.dmem_req_ready_i;
  assign store_done = req_fire & is_store_op(op_q);
  // A load may finish in ISSUE when the response arrives alongside the grant.
  assign load_done  = ((state_q == ISSUE) & req_fire & ~is_store_op(op_q) & dmem.dmem_resp_valid_i)
                    | ((state_q == WAIT_RESP) & dmem.dmem_resp_valid_i);

  always_ff @(posedge clk) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && is_mem_op(op_in)) state_d = ISSUE;
      ISSUE:     if (req_fire) state_d = (is_store_op(op_q) || dmem.dmem_resp_valid_i) ? IDLE : WAIT_RESP;
      WAIT_RESP: if (dmem.dmem_resp_valid_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o               = 1'b0;
    dmem.dmem_req_valid_o = 1'b0;
    case (state_q)
      IDLE:    ready_o = 1'b1;
      ISSUE:   dmem.dmem_req_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Request fields come straight from the latched instruction, so they stay
  // stable for as long as the request waits for ready.
  mem_byte_lane u_byte_lane (
    .op         (op_q),
    .addr       (addr_q[1:0]),
    .store_data (sdata_q),
    .resp_data  (dmem.dmem_resp_data_i),
    .mask       (lane_mask),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  assign dmem.dmem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign dmem.dmem_mask_o  = lane_mask;
  assign dmem.dmem_wdata_o = lane_wdata;
  assign dmem.dmem_we_o    = is_store_op(op_q);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      op_q       <= NONE;
      addr_q     <= '0;
      sdata_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_valid_o <= 1'b0;
      wb_en_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      wb_en_o    <= 1'b0;
      if (accept) begin
        if (is_mem_op(op_in)) begin
          op_q      <= op_in;
          addr_q    <= result_i;
          sdata_q   <= store_data_i;
          wb_en_q   <= wb_en_i;
          wb_addr_q <= wb_addr_i;
        end else begin
          wb_valid_o <= 1'b1;
          wb_en_o    <= wb_en_i;
          wb_addr_o  <= wb_addr_i;
          wb_data_o  <= result_i;
        end
      end
      if (store_done) begin
        wb_valid_o <= 1'b1;
        wb_addr_o  <= wb_addr_q;
      end
      if (load_done) begin
        wb_valid_o <= 1'b1;
        wb_en_o    <= wb_en_q;
        wb_addr_o  <= wb_addr_q;
        wb_data_o  <= lane_load;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions checked against a behavioural writeback/request model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  // Scoreboard entry: {is_store, wb_en, wb_addr[4:0], wb_data[31:0]}
  localparam int W = 39;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] result_i = '0;
  logic [31:0] store_data_i = '0;
  logic [2:0]  mem_op_i = '0;
  logic        wb_en_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic        wb_valid_o, wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  mem_state_e  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int checks = 0;
  int errors = 0;

  mem_stage_if dmem ();

  mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .result_i     (result_i),
    .store_data_i (store_data_i),
    .mem_op_i     (mem_op_i),
    .wb_en_i      (wb_en_i),
    .wb_addr_i    (wb_addr_i),
    .dmem         (dmem),
    .wb_valid_o   (wb_valid_o),
    .wb_en_o      (wb_en_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    dmem.dmem_req_ready_i  = 1'b0;
    dmem.dmem_resp_valid_i = 1'b0;
    dmem.dmem_resp_data_i  = '0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_wb(mem_op_e op, logic [31:0] res, logic en,
                                            logic [4:0] wa, logic [31:0] word);
    int unsigned lane;
    lane = res % 4;
    case (op)
      LW:      return {1'b0, en, wa, word};
      LBU:     return {1'b0, en, wa, (word / (32'd1 << (8 * lane))) % 32'd256};
      SW, SB:  return {1'b1, 1'b0, wa, 32'h0};
      default: return {1'b0, en, wa, res};
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (wb_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got en=%b addr=%0d data=%h exp no packet", wb_en_o, wb_addr_o, wb_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (wb_en_o !== mon_e[37] ||
            (!mon_e[38] && (wb_addr_o !== mon_e[36:32] || wb_data_o !== mon_e[31:0]))) begin
          errors++;
          $display("FAIL wb_packet got en=%b addr=%0d data=%h exp en=%b addr=%0d data=%h",
                   wb_en_o, wb_addr_o, wb_data_o, mon_e[37], mon_e[36:32], mon_e[31:0]);
        end
      end
    end else begin
      checks++;
      if (wb_en_o !== 1'b0) begin
        errors++;
        $display("FAIL wb_en_idle got %b exp 0", wb_en_o);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends one cycle past a rising edge.
  task automatic run_instr(input mem_op_e op, input logic [31:0] res, input logic [31:0] sd,
                           input logic en, input logic [4:0] wa, input int req_dly,
                           input int resp_dly, input logic [31:0] word);
    logic        is_mem, is_st;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    is_mem  = (op != NONE);
    is_st   = (op == SW) || (op == SB);
    e_addr  = res - (res % 4);
    e_mask  = (op == LW || op == SW) ? 4'hF : 4'(1 << (res % 4));
    e_wdata = (op == SB) ? ({24'h0, sd[7:0]} * 32'h0101_0101) : sd;

    valid_i = 1'b1; mem_op_i = op; result_i = res; store_data_i = sd;
    wb_en_i = en; wb_addr_i = wa;
    exp_q.push_back(model_wb(op, res, en, wa, word));
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b exp 1", ready_o);
    end
    step();
    valid_i = 1'b0;
    if (!is_mem) return;

    for (int i = 0; i <= req_dly; i++) begin
      dmem.dmem_req_ready_i  = (i == req_dly);
      dmem.dmem_resp_valid_i = is_st ? 1'($urandom_range(0, 1)) : (i == req_dly && resp_dly == 0);
      dmem.dmem_resp_data_i  = (!is_st && dmem.dmem_resp_valid_i) ? word : $urandom;
      @(negedge clk);
      checks++;
      if ({dmem.dmem_req_valid_o, dmem.dmem_addr_o, dmem.dmem_mask_o, dmem.dmem_wdata_o,
           dmem.dmem_we_o, ready_o, dbg_state} !==
          {1'b1, e_addr, e_mask, e_wdata, is_st, 1'b0, ISSUE}) begin
        errors++;
        $display("FAIL req_hold got v=%b a=%h m=%h d=%h we=%b rdy=%b st=%0d exp v=1 a=%h m=%h d=%h we=%b rdy=0 st=%0d",
                 dmem.dmem_req_valid_o, dmem.dmem_addr_o, dmem.dmem_mask_o, dmem.dmem_wdata_o,
                 dmem.dmem_we_o, ready_o, dbg_state, e_addr, e_mask, e_wdata, is_st, ISSUE);
      end
      step();
    end
    dmem.dmem_req_ready_i  = 1'b0;
    dmem.dmem_resp_valid_i = 1'b0;

    if (!is_st && resp_dly > 0) begin
      for (int i = 1; i <= resp_dly; i++) begin
        dmem.dmem_resp_valid_i = (i == resp_dly);
        dmem.dmem_resp_data_i  = (i == resp_dly) ? word : $urandom;
        @(negedge clk);
        checks++;
        if (dmem.dmem_req_valid_o !== 1'b0 || ready_o !== 1'b0 || dbg_state !== WAIT_RESP) begin
          errors++;
          $display("FAIL wait_resp got v=%b rdy=%b st=%0d exp v=0 rdy=0 st=%0d",
                   dmem.dmem_req_valid_o, ready_o, dbg_state, WAIT_RESP);
        end
        step();
      end
      dmem.dmem_resp_valid_i = 1'b0;
    end

    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b1 || dbg_state !== IDLE || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL done_latency got wb_valid=%b st=%0d rdy=%b exp 1 %0d 1", wb_valid_o, dbg_state, ready_o, IDLE);
    end
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if ({wb_valid_o, wb_en_o, wb_addr_o, wb_data_o, dmem.dmem_req_valid_o, dmem.dmem_addr_o,
         dmem.dmem_mask_o, dmem.dmem_wdata_o, dmem.dmem_we_o} !== '0 || ready_o !== 1'b1 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs got wb=%b/%b/%0d/%h req=%b/%h/%h/%h/%b rdy=%b st=%0d exp all 0 rdy=1 st=0",
               wb_valid_o, wb_en_o, wb_addr_o, wb_data_o, dmem.dmem_req_valid_o, dmem.dmem_addr_o,
               dmem.dmem_mask_o, dmem.dmem_wdata_o, dmem.dmem_we_o, ready_o, dbg_state);
    end
    step();
    n_reset = 1'b1;
    dmem.dmem_resp_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dmem.dmem_resp_data_i = $urandom;
      @(negedge clk);
      checks++;
      if (wb_valid_o !== 1'b0 || dbg_state !== IDLE || ready_o !== 1'b1) begin
        errors++;
        $display("FAIL idle_resp_ignored got wb_valid=%b st=%0d rdy=%b exp 0 0 1", wb_valid_o, dbg_state, ready_o);
      end
      step();
    end
    dmem.dmem_resp_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; mem_op_i = NONE; result_i = 32'(i + 1); store_data_i = $urandom;
      wb_en_i = 1'b1; wb_addr_i = 5'(4 + i);
      exp_q.push_back(model_wb(NONE, 32'(i + 1), 1'b1, 5'(4 + i), 32'h0));
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || (i > 0 && (wb_valid_o !== 1'b1 || wb_data_o !== 32'(i)))) begin
        errors++;
        $display("FAIL b2b_stream got rdy=%b wb_valid=%b data=%h exp rdy=1 wb_valid=%b data=%h",
                 ready_o, wb_valid_o, wb_data_o, (i > 0), 32'(i));
      end
      step();
    end
    valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'd3 || wb_addr_o !== 5'd6) begin
      errors++;
      $display("FAIL b2b_last got wb_valid=%b data=%h addr=%0d exp 1 00000003 6", wb_valid_o, wb_data_o, wb_addr_o);
    end
    step();
  endtask

  task automatic test_sb_delayed();
    run_instr(SB, 32'h0000_0103, 32'h0000_00AB, 1'b1, 5'd9, 2, 0, 32'h0);
  endtask

  task automatic test_lbu();
    run_instr(LBU, 32'h0000_0202, 32'h0, 1'b1, 5'd10, 0, 2, 32'h1122_3344);
  endtask

  task automatic test_lw_same_cycle();
    run_instr(LW, 32'h0000_0404, 32'h0, 1'b1, 5'd11, 0, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_reset_in_wait();
    valid_i = 1'b1; mem_op_i = LW; result_i = 32'h0000_0500; wb_en_i = 1'b1; wb_addr_i = 5'd12;
    step();
    valid_i = 1'b0;
    dmem.dmem_req_ready_i = 1'b1;
    step();
    dmem.dmem_req_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== WAIT_RESP) begin
      errors++;
      $display("FAIL enter_wait got st=%0d exp %0d", dbg_state, WAIT_RESP);
    end
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    dmem.dmem_resp_valid_i = 1'b1;
    dmem.dmem_resp_data_i  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid_o !== 1'b0 || dmem.dmem_req_valid_o !== 1'b0 || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL reset_abandon got wb_valid=%b req_valid=%b st=%0d exp 0 0 0",
                 wb_valid_o, dmem.dmem_req_valid_o, dbg_state);
      end
      step();
    end
    dmem.dmem_resp_valid_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      run_instr(mem_op_e'($urandom_range(0, 4)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
  endtask

  task automatic test_drain();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_sb_delayed();
    test_lbu();
    test_lw_same_cycle();
    test_reset_in_wait();
    test_random();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
